// File: rtl/ram_access_pkg.sv
// Shared constants for the RAM access controller: default RAM geometry,
// FSM state encoding and a small elaboration-time helper.
package ram_access_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_W_SETUP = 3'd1;
  localparam state_t ST_W_PULSE = 3'd2;
  localparam state_t ST_W_HOLD  = 3'd3;
  localparam state_t ST_R_WAIT  = 3'd4;
  localparam state_t ST_RESP    = 3'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response channels between a client and the RAM access controller.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. Once raised, valid and its payload stay stable until that
// edge; ready may depend on controller state but never on valid.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_access_wait_counter.sv
// Loadable down-counter with a zero flag; times both the write strobe
// width and the read access wait.
module ram_access_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Decrement saturates at zero so a stray dec can never wrap the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front-end for a level-strobed 32-bit RAM. Sequences the
// write strobe with one cycle of address/data setup and hold around it.
module ram_access_ctrl
  import ram_access_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int WRITE_PULSE = 1,
  parameter int READ_WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_is_write,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int MAX_WAIT = max_int(WRITE_PULSE, READ_WAIT);
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WRITE_PULSE - 1);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             capture;

  assign accept = bus.req_valid && (state == ST_IDLE);

  ram_access_wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nx     = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bus.req_write) begin
            state_nx = ST_W_SETUP;
          end else begin
            state_nx     = ST_R_WAIT;
            cnt_load     = 1'b1;
            cnt_load_val = READ_LOAD;
          end
        end
      end
      ST_W_SETUP: begin
        state_nx     = ST_W_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = PULSE_LOAD;
      end
      ST_W_PULSE: begin
        if (cnt_zero) state_nx = ST_W_HOLD;
        else          cnt_dec  = 1'b1;
      end
      ST_W_HOLD: begin
        state_nx = ST_IDLE;
      end
      ST_R_WAIT: begin
        if (cnt_zero) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Strobe is a flop decoded from the next state so it cannot glitch, and the
  // async reset clears it without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ram_address  <= '0;
      ram_in       <= '0;
      ram_is_write <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state        <= state_nx;
      ram_is_write <= (state_nx == ST_W_PULSE);
      if (accept) begin
        ram_address <= bus.req_addr;
        if (bus.req_write) ram_in <= bus.req_wdata;
      end
      if (capture) bus.rsp_rdata <= ram_out;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two instances (default and stretched timing),
// each driving a behavioural 64x32 RAM; read data checked via a scoreboard.
module tb_ram_access_ctrl;
  import ram_access_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-timing instance ----------------
  ram_access_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus1 ();
  logic [5:0]  ram_address;
  logic [31:0] ram_in;
  logic        ram_is_write;
  logic [31:0] ram_out;
  logic        busy;
  state_t      dbg_state;
  logic [31:0] mem1 [64];

  ram_access_ctrl #(.ADDR_W(6), .DATA_W(32), .WRITE_PULSE(1), .READ_WAIT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus1),
    .ram_address  (ram_address),
    .ram_in       (ram_in),
    .ram_is_write (ram_is_write),
    .ram_out      (ram_out),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  always @(posedge clk) if (ram_is_write) mem1[ram_address] <= ram_in;
  assign ram_out = mem1[ram_address];

  // ---------------- stretched-timing instance ----------------
  ram_access_ctrl_if #(.ADDR_W(6), .DATA_W(32)) bus2 ();
  logic [5:0]  b_ram_address;
  logic [31:0] b_ram_in;
  logic        b_ram_is_write;
  logic [31:0] b_ram_out;
  logic        b_busy;
  state_t      b_dbg_state;
  logic [31:0] mem2 [64];

  ram_access_ctrl #(.ADDR_W(6), .DATA_W(32), .WRITE_PULSE(3), .READ_WAIT(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus2),
    .ram_address  (b_ram_address),
    .ram_in       (b_ram_in),
    .ram_is_write (b_ram_is_write),
    .ram_out      (b_ram_out),
    .busy         (b_busy),
    .dbg_state    (b_dbg_state)
  );

  always @(posedge clk) if (b_ram_is_write) mem2[b_ram_address] <= b_ram_in;
  assign b_ram_out = mem2[b_ram_address];

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [64];
  logic [31:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus1.rsp_valid && bus1.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_rdata", {32'd0, bus1.rsp_rdata}, {32'd0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    drive_slot();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1;
    bus1.req_addr  = a;    bus1.req_wdata = d;
    @(negedge clk); check("wr_ready_idle", bus1.req_ready, 1);
    drive_slot();
    bus1.req_valid = 1'b0;
    bus1.req_addr  = 6'($urandom); bus1.req_wdata = $urandom;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("wr_is_write", ram_is_write, (k == 2));
      check("wr_req_ready", bus1.req_ready, (k == 4));
      if (k <= 3) begin
        check("wr_addr_stable", ram_address, a);
        check("wr_data_stable", ram_in, d);
      end
    end
    model[a] = d;
  endtask

  task automatic do_read(input logic [5:0] a, input int hold);
    logic [31:0] e;
    e = model[a];
    exp_q.push_back(e);
    drive_slot();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = a;
    bus1.rsp_ready = (hold == 0);
    @(negedge clk); check("rd_ready_idle", bus1.req_ready, 1);
    drive_slot();
    bus1.req_valid = 1'b0;
    @(negedge clk);
    check("rd_wait_valid", bus1.rsp_valid, 0);
    check("rd_wait_busy", busy, 1);
    check("rd_addr", ram_address, a);
    @(negedge clk);
    check("rd_valid_n2", bus1.rsp_valid, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i > 0) @(negedge clk);
        check("rd_stall_valid", bus1.rsp_valid, 1);
        check("rd_stall_data", bus1.rsp_rdata, e);
        check("rd_stall_ready", bus1.req_ready, 0);
      end
      drive_slot();
      bus1.rsp_ready = 1'b1;
      @(negedge clk); check("rd_release_valid", bus1.rsp_valid, 1);
    end
    @(negedge clk);
    check("rd_done_valid", bus1.rsp_valid, 0);
    check("rd_done_ready", bus1.req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.rsp_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0;   bus2.rsp_ready = 1'b1;

    #3;
    check("rst_req_ready", bus1.req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_is_write", ram_is_write, 0);
    check("rst_rsp_valid", bus1.rsp_valid, 0);
    check("rst_address", ram_address, 0);
    check("rst_rdata", bus1.rsp_rdata, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed write/read of addr 43, then addr 28 with 43 left intact.
    do_write(6'd43, 32'hE5F84AB1);
    do_read(6'd43, 0);
    do_write(6'd28, 32'h5C8C6A01);

    // Back-to-back reads 28 then 43: second accepted three cycles after first.
    exp_q.push_back(model[28]);
    exp_q.push_back(model[43]);
    drive_slot();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 6'd28;
    @(negedge clk); check("b2b_rd_ready0", bus1.req_ready, 1);
    drive_slot();
    bus1.req_addr = 6'd43;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); check("b2b_rd_ready", bus1.req_ready, (k == 3));
    end
    drive_slot();
    bus1.req_valid = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      @(negedge clk); check("b2b_rd_valid", bus1.rsp_valid, (k == 5));
    end

    // Back-to-back writes: second accepted four cycles after first.
    drive_slot();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1;
    bus1.req_addr = 6'd50; bus1.req_wdata = 32'h1234_5678;
    @(negedge clk);
    drive_slot();
    bus1.req_addr = 6'd51; bus1.req_wdata = 32'h9ABC_DEF0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); check("b2b_wr_ready", bus1.req_ready, (k == 4));
    end
    drive_slot();
    bus1.req_valid = 1'b0;
    model[50] = 32'h1234_5678;
    model[51] = 32'h9ABC_DEF0;
    repeat (4) @(negedge clk);
    do_read(6'd50, 0);
    do_read(6'd51, 0);

    // Stalled response, then confirm 43 survived the write to 28.
    do_read(6'd28, 5);
    do_read(6'd43, 0);

    // Dropped request without a handshake has no effect.
    drive_slot();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 6'd43;
    #1 bus1.req_valid = 1'b0;
    @(negedge clk); check("drop_busy", busy, 0);
    do_read(6'd43, 0);

    // Random traffic including boundary addresses 0 and 63.
    do_write(6'd0, 32'hA5A5_0001);
    do_write(6'd63, 32'h5A5A_FFFE);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] ra;
      ra = 6'($urandom_range(1, 62));
      do_write(ra, $urandom);
      do_read(ra, $urandom_range(0, 2));
    end
    do_read(6'd0, 0);
    do_read(6'd63, 0);

    // Stretched-timing instance: 3-cycle strobe, 2-cycle read wait.
    drive_slot();
    bus2.req_valid = 1'b1; bus2.req_write = 1'b1;
    bus2.req_addr = 6'd0;  bus2.req_wdata = 32'hFFFF_FFFF;
    @(negedge clk); check("b_wr_ready_idle", bus2.req_ready, 1);
    drive_slot();
    bus2.req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("b_wr_is_write", b_ram_is_write, (k >= 2 && k <= 4));
      check("b_wr_ready", bus2.req_ready, (k == 6));
      if (k <= 5) check("b_wr_addr", b_ram_address, 0);
    end
    drive_slot();
    bus2.req_valid = 1'b1; bus2.req_write = 1'b0; bus2.req_addr = 6'd0;
    @(negedge clk);
    drive_slot();
    bus2.req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("b_rd_valid", bus2.rsp_valid, (k == 3));
      if (k == 3) check("b_rd_data", bus2.rsp_rdata, 32'hFFFF_FFFF);
    end

    // Reset asserted mid-strobe: strobe must drop with no clock edge.
    drive_slot();
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1;
    bus1.req_addr = 6'd9;  bus1.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    drive_slot();
    bus1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_is_write_pre", ram_is_write, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstw_is_write", ram_is_write, 0);
    check("rstw_address", ram_address, 0);
    check("rstw_ram_in", ram_in, 0);
    check("rstw_busy", busy, 0);
    check("rstw_rsp_valid", bus1.rsp_valid, 0);
    check("rstw_req_ready", bus1.req_ready, 1);
    check("rstw_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_write(6'd5, 32'h0BAD_F00D);
    do_read(6'd5, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    check("watchdog_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
